pipeline_hazard_ctrl: RTL and testbench

//  Drives the ctrl_signal_i input of every pipeline register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).

---
 rtl/pipeline_hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: generates Default/Block/Bubble control for the PC and the
// four pipeline registers. It handles load-use interlocks, EX redirect flushes with a
// fetch-latency shadow, and multi-cycle data-memory waits with a sticky timeout flag.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 32,
  localparam int unsigned CTRL_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [6:0]        ex_opcode_i,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic              ex_wreg_i,
  input  logic              ex_redirect_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic [CTRL_W-1:0] ctrl_pc_o,
  output logic [CTRL_W-1:0] ctrl_if_id_o,
  output logic [CTRL_W-1:0] ctrl_id_ex_o,
  output logic [CTRL_W-1:0] ctrl_ex_mem_o,
  output logic [CTRL_W-1:0] ctrl_mem_wb_o,
  output logic              mem_timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Pipeline-register control encodings (shared with the datapath's defines).
  localparam logic [CTRL_W-1:0] CtrlDefault = 2'd0;
  localparam logic [CTRL_W-1:0] CtrlBlock   = 2'd1;
  localparam logic [CTRL_W-1:0] CtrlBubble  = 2'd2;

  localparam logic [6:0] OpcodeLoad = 7'b0000011;

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StFlush   = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;

  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [FW-1:0] FlushReload = FW'(FLUSH_CYCLES - 1);
  localparam logic [WW-1:0] WaitMax     = WW'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [CTRL_W-1:0] pc_c, if_id_c, id_ex_c, ex_mem_c, mem_wb_c;
  logic              mem_stall;
  logic              load_use;

  assign mem_stall = mem_req_i & ~mem_ack_i;

  // rd == 0 never creates a dependency since x0 is hardwired.
  assign load_use = (ex_opcode_i == OpcodeLoad) && ex_wreg_i && (ex_rd_addr_i != 5'd0) &&
                    ((id_use_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_use_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));

  // Next-state logic and raw per-stage control decisions.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    pc_c        = CtrlDefault;
    if_id_c     = CtrlDefault;
    id_ex_c     = CtrlDefault;
    ex_mem_c    = CtrlDefault;
    mem_wb_c    = CtrlDefault;

    case (state_q)
      StRun: begin
        if (mem_stall) begin
          pc_c       = CtrlBlock;
          if_id_c    = CtrlBlock;
          id_ex_c    = CtrlBlock;
          ex_mem_c   = CtrlBlock;
          mem_wb_c   = CtrlBubble;
          state_d    = StMemWait;
          wait_cnt_d = WW'(1);
        end else if (ex_redirect_i) begin
          if_id_c = CtrlBubble;
          id_ex_c = CtrlBubble;
          if (FLUSH_CYCLES > 1) begin
            state_d     = StFlush;
            flush_cnt_d = FlushReload;
          end
        end else if (load_use) begin
          pc_c    = CtrlBlock;
          if_id_c = CtrlBlock;
          id_ex_c = CtrlBubble;
        end
      end

      StFlush: begin
        if (mem_stall) begin
          // Wrong-path slots are already bubbled, so the remaining flush is dropped.
          pc_c        = CtrlBlock;
          if_id_c     = CtrlBlock;
          id_ex_c     = CtrlBlock;
          ex_mem_c    = CtrlBlock;
          mem_wb_c    = CtrlBubble;
          state_d     = StMemWait;
          wait_cnt_d  = WW'(1);
          flush_cnt_d = '0;
        end else begin
          if_id_c = CtrlBubble;
          if (ex_redirect_i) begin
            id_ex_c     = CtrlBubble;
            flush_cnt_d = FlushReload;
          end else if (flush_cnt_q <= FW'(1)) begin
            state_d     = StRun;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - FW'(1);
          end
        end
      end

      StMemWait: begin
        if (mem_ack_i) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else begin
          pc_c     = CtrlBlock;
          if_id_c  = CtrlBlock;
          id_ex_c  = CtrlBlock;
          ex_mem_c = CtrlBlock;
          mem_wb_c = CtrlBubble;
          if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
          end
        end
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Timeout latches once the wait count reaches the limit while the stall persists.
  always_comb begin
    timeout_d = timeout_q;
    if ((state_d == StMemWait) && (wait_cnt_d == WaitMax)) begin
      timeout_d = 1'b1;
    end
  end

  // Outputs are forced to Default while reset is held.
  always_comb begin
    ctrl_pc_o     = rst ? CtrlDefault : pc_c;
    ctrl_if_id_o  = rst ? CtrlDefault : if_id_c;
    ctrl_id_ex_o  = rst ? CtrlDefault : id_ex_c;
    ctrl_ex_mem_o = rst ? CtrlDefault : ex_mem_c;
    ctrl_mem_wb_o = rst ? CtrlDefault : mem_wb_c;
  end

  // Saturating count of cycles where the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((ctrl_pc_o == CtrlBlock) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_timeout_o = timeout_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes expected responses, a monitor
// pops and compares them on the falling edge of every cycle that has an entry.
module tb_pipeline_hazard_ctrl;

  localparam logic [1:0] D = 2'd0;  // Default
  localparam logic [1:0] K = 2'd1;  // Block
  localparam logic [1:0] B = 2'd2;  // Bubble
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpAlu  = 7'b0110011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       use1, use2, ex_wreg, redir, req, ack;
  logic [6:0] ex_op;
  logic [1:0] c_pc, c_ifid, c_idex, c_exmem, c_memwb;
  logic       tmo;
  logic [3:0] scnt;

  typedef struct {
    string      name;
    logic [1:0] pc, ifid, idex, exmem, memwb;
    logic       tmo;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(3),
    .MEM_TIMEOUT (3),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1_addr_i(id_rs1),
    .id_rs2_addr_i(id_rs2),
    .id_use_rs1_i (use1),
    .id_use_rs2_i (use2),
    .ex_opcode_i  (ex_op),
    .ex_rd_addr_i (ex_rd),
    .ex_wreg_i    (ex_wreg),
    .ex_redirect_i(redir),
    .mem_req_i    (req),
    .mem_ack_i    (ack),
    .ctrl_pc_o    (c_pc),
    .ctrl_if_id_o (c_ifid),
    .ctrl_id_ex_o (c_idex),
    .ctrl_ex_mem_o(c_exmem),
    .ctrl_mem_wb_o(c_memwb),
    .mem_timeout_o(tmo),
    .stall_cnt_o  (scnt)
  );

  always #5 clk = ~clk;

  // Monitor: compares one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    logic [10:0] act, want;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        act  = {c_pc, c_ifid, c_idex, c_exmem, c_memwb, tmo};
        want = {e.pc, e.ifid, e.idex, e.exmem, e.memwb, e.tmo};
        n_tests++;
        if (act !== want || (e.cnt >= 0 && int'(scnt) != e.cnt)) begin
          n_fail++;
          $display("FAIL %s: got pc/ifid/idex/exmem/memwb/tmo=%b cnt=%0d, want %b cnt=%0d",
                   e.name, act, scnt, want, e.cnt);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [1:0] p, input logic [1:0] f,
                     input logic [1:0] d, input logic [1:0] e, input logic [1:0] w,
                     input logic t, input int c);
    exp_t x;
    x.name = nm; x.pc = p; x.ifid = f; x.idex = d; x.exmem = e; x.memwb = w;
    x.tmo = t; x.cnt = c;
    exp_q.push_back(x);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; use1 = 1'b0; use2 = 1'b0;
    ex_op = 7'd0; ex_rd = 5'd0; ex_wreg = 1'b0;
    redir = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  task automatic lu(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] r1,
                    input logic [4:0] r2, input logic u1, input logic u2);
    ex_op = op; ex_rd = rd; ex_wreg = 1'b1;
    id_rs1 = r1; id_rs2 = r2; use1 = u1; use2 = u2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    chk("reset", D, D, D, D, D, 1'b0, 0);
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    nxt();
    do_reset();

    // Load-use on rs1, then one cycle later the EX slot holds the bubble.
    lu(OpLoad, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1);
    chk("lu_rs1", K, K, B, D, D, 1'b0, 0);
    nxt();
    ex_op = 7'd0; ex_wreg = 1'b0; ex_rd = 5'd0;
    chk("lu_rs1_after", D, D, D, D, D, 1'b0, 1);
    nxt();
    lu(OpLoad, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1);
    chk("lu_rs2", K, K, B, D, D, 1'b0, 1);
    nxt();

    // Non-hazard loads and non-load writers.
    lu(OpLoad, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
    chk("lu_x0", D, D, D, D, D, 1'b0, 2);
    nxt();
    lu(OpLoad, 5'd5, 5'd5, 5'd6, 1'b0, 1'b1);
    chk("lu_no_use", D, D, D, D, D, 1'b0, 2);
    nxt();
    lu(OpAlu, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1);
    chk("alu_dep", D, D, D, D, D, 1'b0, 2);
    nxt();
    lu(OpLoad, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1);
    ex_wreg = 1'b0;
    chk("lu_nowreg", D, D, D, D, D, 1'b0, 2);
    nxt();

    // Redirect with a 3-cycle fetch shadow.
    do_reset();
    redir = 1'b1;
    chk("redir_c0", D, B, B, D, D, 1'b0, 0);
    nxt();
    redir = 1'b0;
    chk("redir_c1", D, B, D, D, D, 1'b0, 0);
    nxt();
    chk("redir_c2", D, B, D, D, D, 1'b0, 0);
    nxt();
    chk("redir_c3", D, D, D, D, D, 1'b0, 0);
    nxt();

    // Redirect while flushing reloads the shadow.
    redir = 1'b1;
    chk("rr_c0", D, B, B, D, D, 1'b0, 0);
    nxt();
    chk("rr_c1", D, B, B, D, D, 1'b0, 0);
    nxt();
    redir = 1'b0;
    chk("rr_c2", D, B, D, D, D, 1'b0, 0);
    nxt();
    chk("rr_c3", D, B, D, D, D, 1'b0, 0);
    nxt();
    chk("rr_c4", D, D, D, D, D, 1'b0, 0);
    nxt();

    // Memory stall during flush abandons the flush.
    redir = 1'b1;
    chk("fm_c0", D, B, B, D, D, 1'b0, 0);
    nxt();
    redir = 1'b0; req = 1'b1;
    chk("fm_stall", K, K, K, K, B, 1'b0, 0);
    nxt();
    ack = 1'b1;
    chk("fm_ack", D, D, D, D, D, 1'b0, 1);
    nxt();
    idle();
    chk("fm_after", D, D, D, D, D, 1'b0, 1);
    nxt();

    // Zero-latency access costs no stall.
    req = 1'b1; ack = 1'b1;
    chk("req_ack", D, D, D, D, D, 1'b0, 1);
    nxt();

    // Ack four cycles after request; limit 3 is crossed on the way.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; ack = 1'b0;
      chk($sformatf("mw_%0d", i), K, K, K, K, B, (i >= 3), i);
      nxt();
    end
    ack = 1'b1;
    chk("mw_ack", D, D, D, D, D, 1'b1, 4);
    nxt();
    idle();
    chk("mw_after", D, D, D, D, D, 1'b1, 4);
    nxt();

    // Long wait: timeout after third wait cycle, stall counter saturates at 15.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      req = 1'b1; ack = 1'b0;
      chk($sformatf("to_%0d", i), K, K, K, K, B, (i >= 3), (i > 15) ? 15 : i);
      nxt();
    end
    ack = 1'b1;
    chk("to_ack", D, D, D, D, D, 1'b1, 15);
    nxt();
    idle();
    chk("to_sticky", D, D, D, D, D, 1'b1, 15);
    nxt();

    // Memory wait outranks redirect and load-use; redirect acts after ack.
    do_reset();
    lu(OpLoad, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0);
    redir = 1'b1; req = 1'b1; ack = 1'b0;
    chk("pri_c0", K, K, K, K, B, 1'b0, 0);
    nxt();
    chk("pri_c1", K, K, K, K, B, 1'b0, 1);
    nxt();
    ack = 1'b1;
    chk("pri_ack", D, D, D, D, D, 1'b0, 2);
    nxt();
    req = 1'b0; ack = 1'b0;
    chk("pri_redir", D, B, B, D, D, 1'b0, 2);
    nxt();
    idle();
    chk("pri_flush", D, B, D, D, D, 1'b0, 2);
    nxt();
    rst = 1'b1;
    chk("rst_flush", D, D, D, D, D, 1'b0, 0);
    nxt();
    rst = 1'b0;
    chk("rst_flush_after", D, D, D, D, D, 1'b0, 0);
    nxt();
    req = 1'b1;
    chk("rw_c0", K, K, K, K, B, 1'b0, 0);
    nxt();
    rst = 1'b1;
    chk("rst_wait", D, D, D, D, D, 1'b0, 0);
    nxt();
    rst = 1'b0; req = 1'b0;
    chk("rst_wait_after", D, D, D, D, D, 1'b0, 0);
    nxt();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) nxt();
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
